// File: rtl/ni_output_arbiter_pkg.sv
// Shared router/NI constants for the PE network-interface output arbiter:
// flit info codes, widths, credit defaults and requester indices.
package ni_output_arbiter_pkg;

   localparam int unsigned ROUTER_WIDTH      = 36;
   localparam int unsigned ROUTER_ADDR_WIDTH = 16;
   localparam int unsigned TOT_FIFO_DEPTH    = 8;
   localparam int unsigned CREDIT_CNT_WIDTH  = 4;

   typedef enum logic [3:0] {
      ROUTER_INFO_BROADCAST     = 4'h1,
      ROUTER_INFO_FIN_BROADCAST = 4'h2,
      ROUTER_INFO_UV            = 4'h3,
      ROUTER_INFO_FIN_COMP      = 4'h4,
      ROUTER_INFO_READ          = 4'h5
   } router_info_e;

   typedef enum logic [1:0] {
      ARB_ACT  = 2'd0,
      ARB_PSUM = 2'd1,
      ARB_FIN  = 2'd2,
      ARB_RD   = 2'd3
   } arb_sel_e;

endpackage

// File: rtl/ni_output_arbiter_credit.sv
// ni_credit_counter: saturating downstream credit counter with a sticky
// overflow flag; rdy means at least one credit is available.
module ni_credit_counter #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             rdy,
   output logic             err
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      unique case ({inc, dec})
         2'b10: begin
            // A return with the buffer already fully credited is a protocol error.
            if (count_q == CNT_W'(DEPTH)) err_d = 1'b1;
            else                          count_d = count_q + CNT_W'(1);
         end
         2'b01:   count_d = count_q - CNT_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= CNT_W'(DEPTH);
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign count = count_q;
   assign rdy   = (count_q != '0);
   assign err   = err_q;

endmodule

// File: rtl/ni_output_arbiter.sv
// Credit-aware NI output scheduler: act/psum/FIN_COMP/read onto one flit register.
// Define NI_ARB_RR_EN for round-robin among psum, FIN_COMP and read.
module ni_output_arbiter #(
   parameter int unsigned CREDIT_DEPTH     = ni_output_arbiter_pkg::TOT_FIFO_DEPTH,
   parameter int unsigned CREDIT_CNT_WIDTH = ni_output_arbiter_pkg::CREDIT_CNT_WIDTH,
   parameter int unsigned ADDR_WIDTH       = ni_output_arbiter_pkg::ROUTER_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH       = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [5:0]                  PE_IDX,
   input  logic                        act_req,
   output logic                        act_gnt,
   input  logic [ADDR_WIDTH-1:0]       act_addr,
   input  logic [DATA_WIDTH-1:0]       act_data,
   input  logic                        psum_req,
   output logic                        psum_gnt,
   input  logic [ADDR_WIDTH-1:0]       psum_addr,
   input  logic [DATA_WIDTH-1:0]       psum_data,
   input  logic                        fin_req,
   input  logic                        rd_req,
   output logic                        rd_gnt,
   input  logic [5:0]                  rd_addr,
   input  logic [DATA_WIDTH-1:0]       rd_data,
   input  logic                        downstream_credit,
   output logic                        out_data_valid,
   output logic [35:0]                 out_data,
   output logic [CREDIT_CNT_WIDTH-1:0] credit_count,
   output logic                        fin_pending,
   output logic                        credit_err
);

   import ni_output_arbiter_pkg::*;

   logic        credit_rdy;
   logic        fin_gnt;
   logic        fin_elig;
   logic        any_gnt;
   logic        fin_pending_q, fin_pending_d;
   logic        out_valid_q, out_valid_d;
   logic [35:0] out_data_q, out_data_d;
   router_info_e act_info;

`ifdef NI_ARB_RR_EN
   arb_sel_e rr_ptr_q, rr_ptr_d;
`endif

   ni_credit_counter #(
      .DEPTH (CREDIT_DEPTH),
      .CNT_W (CREDIT_CNT_WIDTH)
   ) u_credit (
      .clk   (clk),
      .rst   (rst),
      .inc   (downstream_credit),
      .dec   (any_gnt),
      .count (credit_count),
      .rdy   (credit_rdy),
      .err   (credit_err)
   );

   // FIN_COMP must never overtake a partial-sum packet still being requested.
   assign fin_elig = fin_pending_q & ~psum_req;

   always_comb begin
      act_gnt  = 1'b0;
      psum_gnt = 1'b0;
      fin_gnt  = 1'b0;
      rd_gnt   = 1'b0;
      if (credit_rdy) begin
         if (act_req) begin
            act_gnt = 1'b1;
         end else begin
`ifdef NI_ARB_RR_EN
            // Search order starts at the pointer; ARB_ACT (reset) behaves as ARB_PSUM.
            unique case (rr_ptr_q)
               ARB_FIN: begin
                  if (fin_elig)      fin_gnt  = 1'b1;
                  else if (rd_req)   rd_gnt   = 1'b1;
                  else if (psum_req) psum_gnt = 1'b1;
               end
               ARB_RD: begin
                  if (rd_req)        rd_gnt   = 1'b1;
                  else if (psum_req) psum_gnt = 1'b1;
                  else if (fin_elig) fin_gnt  = 1'b1;
               end
               default: begin
                  if (psum_req)      psum_gnt = 1'b1;
                  else if (fin_elig) fin_gnt  = 1'b1;
                  else if (rd_req)   rd_gnt   = 1'b1;
               end
            endcase
`else
            if (psum_req)      psum_gnt = 1'b1;
            else if (fin_elig) fin_gnt  = 1'b1;
            else if (rd_req)   rd_gnt   = 1'b1;
`endif
         end
      end
   end

   assign any_gnt = act_gnt | psum_gnt | fin_gnt | rd_gnt;

`ifdef NI_ARB_RR_EN
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (psum_gnt)     rr_ptr_d = ARB_FIN;
      else if (fin_gnt) rr_ptr_d = ARB_RD;
      else if (rd_gnt)  rr_ptr_d = ARB_PSUM;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rr_ptr_q <= ARB_ACT;
      else      rr_ptr_q <= rr_ptr_d;
   end
`endif

   // A repeated fin_req while one is queued, including in its grant cycle, merges.
   always_comb begin
      if (fin_pending_q) fin_pending_d = ~fin_gnt;
      else               fin_pending_d = fin_req;
   end

   always_comb begin
      act_info    = act_addr[ADDR_WIDTH-1] ? ROUTER_INFO_FIN_BROADCAST : ROUTER_INFO_BROADCAST;
      out_valid_d = any_gnt;
      out_data_d  = '0;
      if (act_gnt)       out_data_d = {act_info, act_addr, act_data};
      else if (psum_gnt) out_data_d = {ROUTER_INFO_UV, psum_addr, psum_data};
      else if (fin_gnt)  out_data_d = {ROUTER_INFO_FIN_COMP, 16'h0000, 10'b0, PE_IDX};
      else if (rd_gnt)   out_data_d = {ROUTER_INFO_READ, 4'b0, rd_addr, PE_IDX, rd_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fin_pending_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
      end else begin
         fin_pending_q <= fin_pending_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
      end
   end

   assign fin_pending    = fin_pending_q;
   assign out_data_valid = out_valid_q;
   assign out_data       = out_data_q;

endmodule
